// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned XLEN_DEFAULT       = 32;
  localparam int unsigned STARVE_MAX_DEFAULT = 4;
  localparam int unsigned STARVE_W           = 4;
  localparam int unsigned STRB_W             = 4;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } mem_owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and unified-memory port around the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned XLEN = mem_port_arbiter_pkg::XLEN_DEFAULT
);
  import mem_port_arbiter_pkg::*;

  logic              i_req;
  logic [XLEN-1:0]   i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [XLEN-1:0]   i_rdata;

  logic              d_req;
  logic              d_we;
  logic [XLEN-1:0]   d_addr;
  logic [STRB_W-1:0] d_wstrb;
  logic [XLEN-1:0]   d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [XLEN-1:0]   d_rdata;

  logic [XLEN-1:0]   m_addr;
  logic              m_ren;
  logic              m_wen;
  logic [STRB_W-1:0] m_wstrb;
  logic [XLEN-1:0]   m_wdata;
  logic [XLEN-1:0]   m_rdata;

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wstrb, d_wdata, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output m_addr, m_ren, m_wen, m_wstrb, m_wdata
  );

  // Core requesters plus memory.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wstrb, d_wdata, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  m_addr, m_ren, m_wen, m_wstrb, m_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D); D has priority,
// bounded by a starvation guard, and read responses are routed back to their owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                rd_pend_q, rd_pend_d;
  mem_owner_e          rd_owner_q, rd_owner_d;
  logic                grant_i, grant_d, read_grant;

  // D wins unless I has already watched STARVE_MAX D grants in a row.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!rst) begin
      if (bus.d_req && (!bus.i_req || (starve_cnt_q < STARVE_LIM))) begin
        grant_d = 1'b1;
      end else if (bus.i_req) begin
        grant_i = 1'b1;
      end
    end
    read_grant = grant_i | (grant_d & ~bus.d_we);
  end

  always_comb begin
    bus.m_addr  = bus.d_addr;
    bus.m_wdata = bus.d_wdata;
    bus.m_wstrb = '0;
    bus.m_ren   = 1'b0;
    bus.m_wen   = 1'b0;
    if (grant_i) begin
      bus.m_addr = bus.i_addr;
      bus.m_ren  = 1'b1;
    end else if (grant_d) begin
      bus.m_ren   = ~bus.d_we;
      bus.m_wen   = bus.d_we;
      bus.m_wstrb = bus.d_wstrb;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_i || !bus.i_req) begin
      starve_cnt_d = '0;
    end else if (grant_d) begin
      starve_cnt_d = (starve_cnt_q >= STARVE_LIM) ? STARVE_LIM
                                                  : starve_cnt_q + STARVE_W'(1);
    end

    rd_pend_d  = read_grant;
    rd_owner_d = rd_owner_q;
    if (read_grant) begin
      rd_owner_d = grant_d ? OWNER_D : OWNER_I;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= OWNER_I;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign bus.i_gnt    = grant_i;
  assign bus.d_gnt    = grant_d;
  assign bus.i_rvalid = rd_pend_q & (rd_owner_q == OWNER_I);
  assign bus.d_rvalid = rd_pend_q & (rd_owner_q == OWNER_D);
  assign bus.i_rdata  = bus.m_rdata;
  assign bus.d_rdata  = bus.m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model with its own shadow memory.
module tb_mem_port_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int          SMAX = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.XLEN(XLEN)) bus ();

  mem_port_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] init_word(int k);
    return 32'h1000_0000 + 32'(k) * 32'h0001_0103;
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  // Synchronous memory: write lands at the edge, read data appears after the edge.
  logic [31:0] mem [256];
  initial begin
    for (int k = 0; k < 256; k++) mem[k] = init_word(k);
    bus.m_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.m_ren) bus.m_rdata <= mem[widx(bus.m_addr)];
      if (bus.m_wen)
        for (int b = 0; b < 4; b++)
          if (bus.m_wstrb[b]) mem[widx(bus.m_addr)][8*b +: 8] = bus.m_wdata[8*b +: 8];
    end
  end

  // Reference model: who should win, and which response is due this cycle.
  logic [31:0] shadow [256];
  int          d_streak;      // D grants since I started waiting
  bit          e_i, e_d;
  bit          rsp_v, rsp_is_d;
  logic [31:0] rsp_data;

  task automatic model_eval();
    e_d = !rst && bus.d_req && (!bus.i_req || d_streak < SMAX);
    e_i = !rst && bus.i_req && !e_d;
  endtask

  task automatic model_advance();
    rsp_v = 1'b0;
    if (rst) begin
      d_streak = 0;
      return;
    end
    if (e_i) begin
      rsp_v = 1'b1; rsp_is_d = 1'b0; rsp_data = shadow[widx(bus.i_addr)];
    end else if (e_d && !bus.d_we) begin
      rsp_v = 1'b1; rsp_is_d = 1'b1; rsp_data = shadow[widx(bus.d_addr)];
    end else if (e_d) begin
      for (int b = 0; b < 4; b++)
        if (bus.d_wstrb[b]) shadow[widx(bus.d_addr)][8*b +: 8] = bus.d_wdata[8*b +: 8];
    end
    d_streak = (e_d && bus.i_req) ? d_streak + 1 : 0;
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic next_cycle();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    for (int k = 0; k < n; k++) begin
      sample();
      next_cycle();
    end
  endtask

  task automatic test_reset();
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    sample();
    checks++; if (bus.i_gnt !== 1'b0)    begin errors++; $display("FAIL reset_i_gnt got %b want 0", bus.i_gnt); end
    checks++; if (bus.d_gnt !== 1'b0)    begin errors++; $display("FAIL reset_d_gnt got %b want 0", bus.d_gnt); end
    checks++; if (bus.m_ren !== 1'b0)    begin errors++; $display("FAIL reset_m_ren got %b want 0", bus.m_ren); end
    checks++; if (bus.m_wen !== 1'b0)    begin errors++; $display("FAIL reset_m_wen got %b want 0", bus.m_wen); end
    checks++; if (bus.i_rvalid !== 1'b0) begin errors++; $display("FAIL reset_i_rvalid got %b want 0", bus.i_rvalid); end
    checks++; if (bus.d_rvalid !== 1'b0) begin errors++; $display("FAIL reset_d_rvalid got %b want 0", bus.d_rvalid); end
    next_cycle();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_i_only();
    bus.i_req = 1'b1; bus.i_addr = 32'h0;
    sample();
    checks++; if (bus.i_gnt !== 1'b1)    begin errors++; $display("FAIL ionly_gnt0 got %b want 1", bus.i_gnt); end
    checks++; if (bus.m_ren !== 1'b1 || bus.m_addr !== 32'h0)
      begin errors++; $display("FAIL ionly_mem0 got ren=%b addr=%h want ren=1 addr=0", bus.m_ren, bus.m_addr); end
    next_cycle();
    bus.i_addr = 32'h4;
    sample();
    checks++; if (bus.i_gnt !== 1'b1)    begin errors++; $display("FAIL ionly_gnt1 got %b want 1", bus.i_gnt); end
    checks++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== init_word(0))
      begin errors++; $display("FAIL ionly_rsp0 got v=%b %h want v=1 %h", bus.i_rvalid, bus.i_rdata, init_word(0)); end
    next_cycle();
    bus.i_req = 1'b0;
    sample();
    checks++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== init_word(1))
      begin errors++; $display("FAIL ionly_rsp1 got v=%b %h want v=1 %h", bus.i_rvalid, bus.i_rdata, init_word(1)); end
    checks++; if (bus.d_rvalid !== 1'b0) begin errors++; $display("FAIL ionly_d_rvalid got %b want 0", bus.d_rvalid); end
    next_cycle();
    sample();
    checks++; if (bus.i_rvalid !== 1'b0) begin errors++; $display("FAIL ionly_idle got %b want 0", bus.i_rvalid); end
    next_cycle();
  endtask

  task automatic test_store_load();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100;
    bus.d_wstrb = 4'hF; bus.d_wdata = 32'hFFFF_FFFF;
    sample();
    checks++; if (bus.d_gnt !== 1'b1 || bus.m_wen !== 1'b1)
      begin errors++; $display("FAIL st_fill got gnt=%b wen=%b want 1 1", bus.d_gnt, bus.m_wen); end
    next_cycle();
    bus.d_wstrb = 4'b0011; bus.d_wdata = 32'hDEAD_BEEF;
    sample();
    checks++; if (bus.m_wstrb !== 4'b0011 || bus.m_wdata !== 32'hDEAD_BEEF || bus.m_ren !== 1'b0)
      begin errors++; $display("FAIL st_drive got strb=%b data=%h ren=%b want 0011 deadbeef 0", bus.m_wstrb, bus.m_wdata, bus.m_ren); end
    next_cycle();
    bus.d_we = 1'b0;
    sample();
    checks++; if (bus.d_gnt !== 1'b1 || bus.m_ren !== 1'b1 || bus.m_wen !== 1'b0)
      begin errors++; $display("FAIL ld_drive got gnt=%b ren=%b wen=%b want 1 1 0", bus.d_gnt, bus.m_ren, bus.m_wen); end
    next_cycle();
    bus.d_req = 1'b0;
    sample();
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hFFFF_BEEF)
      begin errors++; $display("FAIL ld_data got v=%b %h want v=1 ffffbeef", bus.d_rvalid, bus.d_rdata); end
    checks++; if (bus.i_rvalid !== 1'b0) begin errors++; $display("FAIL ld_i_rvalid got %b want 0", bus.i_rvalid); end
    next_cycle();
  endtask

  task automatic test_contention();
    bit prev_i;
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b0;
    for (int k = 0; k < 15; k++) begin
      bit want_i;
      bus.i_addr = 32'($urandom_range(0, 255)) << 2;
      bus.d_addr = 32'($urandom_range(0, 255)) << 2;
      want_i = (k % 5) == 4;
      sample();
      checks++; if (bus.i_gnt !== want_i || bus.d_gnt !== !want_i)
        begin errors++; $display("FAIL contend_%0d got i=%b d=%b want i=%b d=%b", k, bus.i_gnt, bus.d_gnt, want_i, !want_i); end
      if (k > 0) begin
        checks++; if (bus.i_rvalid !== prev_i || bus.d_rvalid !== !prev_i)
          begin errors++; $display("FAIL contend_rsp_%0d got i=%b d=%b want i=%b d=%b", k, bus.i_rvalid, bus.d_rvalid, prev_i, !prev_i); end
      end
      prev_i = want_i;
      next_cycle();
    end
    idle(1);
  endtask

  task automatic test_routing();
    bus.i_req = 1'b1; bus.i_addr = 32'h8; bus.d_req = 1'b0;
    sample();
    checks++; if (bus.i_gnt !== 1'b1) begin errors++; $display("FAIL route_i_gnt got %b want 1", bus.i_gnt); end
    next_cycle();
    bus.i_req = 1'b0; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'hC;
    sample();
    checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL route_d_gnt got %b want 1", bus.d_gnt); end
    checks++; if (bus.i_rvalid !== 1'b1 || bus.d_rvalid !== 1'b0 || bus.i_rdata !== init_word(2))
      begin errors++; $display("FAIL route_i_rsp got i=%b d=%b %h want 1 0 %h", bus.i_rvalid, bus.d_rvalid, bus.i_rdata, init_word(2)); end
    next_cycle();
    bus.d_req = 1'b0;
    sample();
    checks++; if (bus.d_rvalid !== 1'b1 || bus.i_rvalid !== 1'b0 || bus.d_rdata !== init_word(3))
      begin errors++; $display("FAIL route_d_rsp got d=%b i=%b %h want 1 0 %h", bus.d_rvalid, bus.i_rvalid, bus.d_rdata, init_word(3)); end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
    sample();
    checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt got %b want 1", bus.d_gnt); end
    rst = 1'b1;
    bus.d_req = 1'b0;
    next_cycle();
    sample();
    checks++; if (bus.d_rvalid !== 1'b0 || bus.i_rvalid !== 1'b0)
      begin errors++; $display("FAIL rmid_in_reset got d=%b i=%b want 0 0", bus.d_rvalid, bus.i_rvalid); end
    next_cycle();
    rst = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h20;
    sample();
    checks++; if (bus.i_gnt !== 1'b1 || bus.d_rvalid !== 1'b0)
      begin errors++; $display("FAIL rmid_release got gnt=%b d_rvalid=%b want 1 0", bus.i_gnt, bus.d_rvalid); end
    next_cycle();
    bus.i_req = 1'b0;
    sample();
    checks++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== init_word(8))
      begin errors++; $display("FAIL rmid_fetch got v=%b %h want v=1 %h", bus.i_rvalid, bus.i_rdata, init_word(8)); end
    next_cycle();
  endtask

  task automatic test_drop();
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h44;
    for (int k = 0; k < SMAX; k++) begin
      sample();
      checks++; if (bus.d_gnt !== 1'b1 || bus.i_gnt !== 1'b0)
        begin errors++; $display("FAIL drop_build_%0d got d=%b i=%b want 1 0", k, bus.d_gnt, bus.i_gnt); end
      next_cycle();
    end
    bus.d_we = 1'b1; bus.d_wstrb = 4'hF; bus.d_wdata = 32'h0BAD_F00D;
    sample();
    checks++; if (bus.i_gnt !== 1'b1 || bus.d_gnt !== 1'b0 || bus.m_wen !== 1'b0)
      begin errors++; $display("FAIL drop_forced got i=%b d=%b wen=%b want 1 0 0", bus.i_gnt, bus.d_gnt, bus.m_wen); end
    next_cycle();
    bus.d_req = 1'b0; bus.i_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      checks++; if (bus.m_wen !== 1'b0 || bus.d_rvalid !== 1'b0)
        begin errors++; $display("FAIL drop_after_%0d got wen=%b d_rvalid=%b want 0 0", k, bus.m_wen, bus.d_rvalid); end
      next_cycle();
    end
  endtask

  task automatic test_random();
    bit gi, gd;
    int i_wait = 0;
    int d_wait = 0;
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    for (int n = 0; n < 400; n++) begin
      sample();
      checks++; if (bus.i_gnt !== e_i || bus.d_gnt !== e_d)
        begin errors++; $display("FAIL rnd_gnt_%0d got i=%b d=%b want i=%b d=%b", n, bus.i_gnt, bus.d_gnt, e_i, e_d); end
      checks++; if (bus.m_ren !== (e_i || (e_d && !bus.d_we)) || bus.m_wen !== (e_d && bus.d_we))
        begin errors++; $display("FAIL rnd_en_%0d got ren=%b wen=%b", n, bus.m_ren, bus.m_wen); end
      if (e_i || e_d) begin
        checks++; if (bus.m_addr !== (e_i ? bus.i_addr : bus.d_addr))
          begin errors++; $display("FAIL rnd_addr_%0d got %h", n, bus.m_addr); end
      end
      checks++; if (bus.i_rvalid !== (rsp_v && !rsp_is_d) || bus.d_rvalid !== (rsp_v && rsp_is_d))
        begin errors++; $display("FAIL rnd_rvalid_%0d got i=%b d=%b want i=%b d=%b", n, bus.i_rvalid, bus.d_rvalid, rsp_v && !rsp_is_d, rsp_v && rsp_is_d); end
      if (rsp_v) begin
        checks++; if ((rsp_is_d ? bus.d_rdata : bus.i_rdata) !== rsp_data)
          begin errors++; $display("FAIL rnd_rdata_%0d got %h want %h", n, rsp_is_d ? bus.d_rdata : bus.i_rdata, rsp_data); end
      end
      i_wait = (bus.i_req && !bus.i_gnt) ? i_wait + 1 : 0;
      d_wait = (bus.d_req && !bus.d_gnt) ? d_wait + 1 : 0;
      if (bus.i_req || bus.d_req) begin
        checks++; if (i_wait > SMAX || d_wait > 1)
          begin errors++; $display("FAIL rnd_wait_%0d got i=%0d d=%0d want <=%0d <=1", n, i_wait, d_wait, SMAX); end
      end
      gi = e_i; gd = e_d;
      next_cycle();
      if (!bus.i_req || gi) begin
        bus.i_req  = $urandom_range(0, 3) != 0;
        bus.i_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if (!bus.d_req || gd) begin
        bus.d_req   = $urandom_range(0, 3) != 0;
        bus.d_we    = $urandom_range(0, 1) != 0;
        bus.d_addr  = 32'($urandom_range(0, 255)) << 2;
        bus.d_wstrb = 4'($urandom_range(0, 15));
        bus.d_wdata = $urandom;
      end
    end
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0;
    bus.d_wstrb = '0; bus.d_wdata = '0;
    for (int k = 0; k < 256; k++) shadow[k] = init_word(k);
    d_streak = 0; rsp_v = 1'b0; rsp_is_d = 1'b0; rsp_data = '0;
    e_i = 1'b0; e_d = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_i_only();
    test_store_load();
    test_contention();
    test_routing();
    test_reset_mid_read();
    test_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
